// File: rtl/dkong_rom_loader.sv
// Routes the HPS ioctl download stream into the Donkey Kong ROM regions, captures
// the mod/DIP bytes and holds the game core in reset until a full ROM image has landed.
module dkong_rom_loader #(
   parameter int CPU_SIZE    = 32768,
   parameter int SND_BASE    = 'hE000,
   parameter int WAV_BASE    = 'h10000,
   parameter int HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        cpu_wr,
   output logic [14:0] cpu_addr,
   output logic        snd_wr,
   output logic [11:0] snd_addr,
   output logic        wav_wr,
   output logic [15:0] wav_addr,
   output logic [7:0]  wr_data,
   output logic [7:0]  mod,
   output logic [63:0] dip_sw,
   output logic        core_reset,
   output logic        rom_ready,
   output logic [15:0] checksum,
   output logic [24:0] byte_count,
   output logic        oor_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_HOLD  = 2'd2,
      S_READY = 2'd3
   } state_t;

   localparam logic [24:0] L_CPU_END  = 25'(CPU_SIZE);
   localparam logic [24:0] L_SND_BASE = 25'(SND_BASE);
   localparam logic [24:0] L_SND_END  = 25'(SND_BASE + 4096);
   localparam logic [24:0] L_WAV_BASE = 25'(WAV_BASE);
   localparam logic [24:0] L_WAV_END  = 25'(WAV_BASE + 65536);

   state_t      r_state, w_next;
   logic [7:0]  r_hold_cnt;
   logic        r_core_reset, r_rom_ready;
   logic        r_cpu_wr, r_snd_wr, r_wav_wr, r_oor_err;
   logic [14:0] r_cpu_addr;
   logic [11:0] r_snd_addr;
   logic [15:0] r_wav_addr, r_checksum;
   logic [7:0]  r_wr_data, r_mod;
   logic [63:0] r_dip_sw;
   logic [24:0] r_byte_count;

   logic        w_rom_start, w_acc, w_in_cpu, w_in_snd, w_in_wav, w_enter_load;
   logic [11:0] w_snd_off;
   logic [15:0] w_wav_off;
   logic [15:0] w_sum_base;
   logic [24:0] w_cnt_base;
   logic        w_oor_base;

   assign w_rom_start  = ioctl_download & (ioctl_index == 8'd0);
   assign w_acc        = ioctl_wr & w_rom_start;
   assign w_in_cpu     = (ioctl_addr < L_CPU_END);
   assign w_in_snd     = (ioctl_addr >= L_SND_BASE) & (ioctl_addr < L_SND_END);
   assign w_in_wav     = (ioctl_addr >= L_WAV_BASE) & (ioctl_addr < L_WAV_END);
   // Region sizes are powers of two, so the low bits of the difference are the offset.
   assign w_snd_off    = ioctl_addr[11:0] - L_SND_BASE[11:0];
   assign w_wav_off    = ioctl_addr[15:0] - L_WAV_BASE[15:0];
   assign w_enter_load = (w_next == S_LOAD) & (r_state != S_LOAD);
   assign w_sum_base   = w_enter_load ? 16'd0 : r_checksum;
   assign w_cnt_base   = w_enter_load ? 25'd0 : r_byte_count;
   assign w_oor_base   = w_enter_load ? 1'b0 : r_oor_err;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_READY: begin
            if (w_rom_start) w_next = S_LOAD;
            else             w_next = r_state;
         end
         S_LOAD: begin
            if (!ioctl_download) w_next = S_HOLD;
            else                 w_next = S_LOAD;
         end
         S_HOLD: begin
            if (w_rom_start)              w_next = S_LOAD;
            else if (r_hold_cnt == 8'd0)  w_next = S_READY;
            else                          w_next = S_HOLD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_hold_cnt   <= 8'd0;
         r_core_reset <= 1'b1;
         r_rom_ready  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_core_reset <= (w_next != S_READY);
         r_rom_ready  <= (w_next == S_READY);
         if ((r_state == S_LOAD) && (w_next == S_HOLD))
            r_hold_cnt <= 8'(HOLD_CYCLES);
         else if ((r_state == S_HOLD) && (r_hold_cnt != 8'd0))
            r_hold_cnt <= r_hold_cnt - 8'd1;
         else
            r_hold_cnt <= r_hold_cnt;
      end
   end

   // Write pipeline, diagnostics and the side-channel configuration bytes.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_cpu_wr     <= 1'b0;
         r_snd_wr     <= 1'b0;
         r_wav_wr     <= 1'b0;
         r_cpu_addr   <= 15'd0;
         r_snd_addr   <= 12'd0;
         r_wav_addr   <= 16'd0;
         r_wr_data    <= 8'd0;
         r_checksum   <= 16'd0;
         r_byte_count <= 25'd0;
         r_oor_err    <= 1'b0;
         r_mod        <= 8'd0;
         r_dip_sw     <= 64'd0;
      end else begin
         r_cpu_wr   <= w_acc & w_in_cpu;
         r_snd_wr   <= w_acc & w_in_snd;
         r_wav_wr   <= w_acc & w_in_wav;
         r_cpu_addr <= ioctl_addr[14:0];
         r_snd_addr <= w_snd_off;
         r_wav_addr <= w_wav_off;
         r_wr_data  <= ioctl_dout;
         if (w_acc) begin
            r_checksum   <= w_sum_base + {8'd0, ioctl_dout};
            r_byte_count <= w_cnt_base + 25'd1;
            r_oor_err    <= w_oor_base | ~(w_in_cpu | w_in_snd | w_in_wav);
         end else begin
            r_checksum   <= w_sum_base;
            r_byte_count <= w_cnt_base;
            r_oor_err    <= w_oor_base;
         end
         if (ioctl_wr && ioctl_download && (ioctl_index == 8'd1))
            r_mod <= ioctl_dout;
         else
            r_mod <= r_mod;
         if (ioctl_wr && ioctl_download && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0))
            r_dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
         else
            r_dip_sw <= r_dip_sw;
      end
   end

   assign cpu_wr     = r_cpu_wr;
   assign cpu_addr   = r_cpu_addr;
   assign snd_wr     = r_snd_wr;
   assign snd_addr   = r_snd_addr;
   assign wav_wr     = r_wav_wr;
   assign wav_addr   = r_wav_addr;
   assign wr_data    = r_wr_data;
   assign mod        = r_mod;
   assign dip_sw     = r_dip_sw;
   assign core_reset = r_core_reset;
   assign rom_ready  = r_rom_ready;
   assign checksum   = r_checksum;
   assign byte_count = r_byte_count;
   assign oor_err    = r_oor_err;

endmodule

// File: tb/tb_dkong_rom_loader.sv
// Randomized self-checking bench for dkong_rom_loader against a region/sum/count
// reference model computed from the address map and download rules.
module tb_dkong_rom_loader;

   localparam int HOLD = 16;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        cpu_wr, snd_wr, wav_wr, core_reset, rom_ready, oor_err;
   logic [14:0] cpu_addr;
   logic [11:0] snd_addr;
   logic [15:0] wav_addr, checksum;
   logic [7:0]  wr_data, mod;
   logic [63:0] dip_sw;
   logic [24:0] byte_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] m_sum;
   logic [24:0] m_cnt;
   logic        m_oor;
   logic [7:0]  m_mod;
   logic [7:0]  m_dip [8];

   always #5 clk_sys = ~clk_sys;

   dkong_rom_loader #(.CPU_SIZE(32768), .SND_BASE('hE000), .WAV_BASE('h10000), .HOLD_CYCLES(HOLD)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .snd_wr(snd_wr), .snd_addr(snd_addr), .wav_wr(wav_wr), .wav_addr(wav_addr),
      .wr_data(wr_data), .mod(mod), .dip_sw(dip_sw), .core_reset(core_reset),
      .rom_ready(rom_ready), .checksum(checksum), .byte_count(byte_count),
      .oor_err(oor_err)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 0 = CPU, 1 = sound, 2 = waveform, 3 = outside every region
   function automatic int region_of(input int a);
      if (a < 32768)                      return 0;
      else if (a >= 57344 && a < 61440)   return 1;
      else if (a >= 65536 && a < 131072)  return 2;
      else                                return 3;
   endfunction

   function automatic logic [63:0] model_dip();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_dip[i];
      return v;
   endfunction

   task automatic model_clear_all();
      m_sum = 16'd0; m_cnt = 25'd0; m_oor = 1'b0; m_mod = 8'd0;
      for (int i = 0; i < 8; i++) m_dip[i] = 8'd0;
   endtask

   // One byte strobe; outputs checked one cycle later. Successive calls give back-to-back writes.
   task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      int rg;
      int a;
      ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      a = int'(addr);
      rg = (idx == 8'd0) ? region_of(a) : 3;
      if (idx == 8'd0) begin
         m_sum = m_sum + {8'd0, data};
         m_cnt = m_cnt + 25'd1;
         if (rg == 3) m_oor = 1'b1;
      end else if (idx == 8'd1) begin
         m_mod = data;
      end else if (idx == 8'd254 && a < 8) begin
         m_dip[a] = data;
      end
      check_val("cpu_wr", cpu_wr, rg == 0);
      check_val("snd_wr", snd_wr, rg == 1);
      check_val("wav_wr", wav_wr, rg == 2);
      if (rg == 0) check_val("cpu_addr", cpu_addr, a);
      if (rg == 1) check_val("snd_addr", snd_addr, a - 57344);
      if (rg == 2) check_val("wav_addr", wav_addr, a - 65536);
      if (rg != 3) check_val("wr_data", wr_data, data);
      check_val("checksum", checksum, m_sum);
      check_val("byte_count", byte_count, m_cnt);
      check_val("oor_err", oor_err, m_oor);
      check_val("mod", mod, m_mod);
      check_val("dip_sw", dip_sw, model_dip());
   endtask

   task automatic start_dl();
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      @(posedge clk_sys); #1;
      m_sum = 16'd0; m_cnt = 25'd0; m_oor = 1'b0;
      check_val("dl_rom_ready", rom_ready, 1'b0);
      check_val("dl_core_reset", core_reset, 1'b1);
      check_val("dl_checksum_clr", checksum, 16'd0);
      check_val("dl_count_clr", byte_count, 25'd0);
      check_val("dl_oor_clr", oor_err, 1'b0);
   endtask

   task automatic end_dl_wait_ready();
      int n;
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      n = 0;
      while (!rom_ready && n < 300) begin
         check_val("hold_core_reset", core_reset, 1'b1);
         @(posedge clk_sys); #1;
         n++;
      end
      check_val("ready_latency", n, HOLD + 1);
      check_val("ready_core_reset", core_reset, 1'b0);
   endtask

   function automatic logic [24:0] rand_addr();
      case ($urandom_range(0, 4))
         0:       return 25'($urandom_range(0, 32767));
         1:       return 25'(57344 + $urandom_range(0, 4095));
         2:       return 25'(65536 + $urandom_range(0, 65535));
         3:       return 25'(32768 + $urandom_range(0, 24575));
         default: return 25'(131072 + $urandom_range(0, 1000000));
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear_all();
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_sys); #1;
         check_val("idle_strobes", {cpu_wr, snd_wr, wav_wr}, 3'b000);
      end
      check_val("rst_core_reset", core_reset, 1'b1);
      check_val("rst_rom_ready", rom_ready, 1'b0);
      check_val("rst_mod", mod, 8'd0);
      check_val("rst_dip", dip_sw, 64'd0);
      check_val("rst_checksum", checksum, 16'd0);

      // Directed region boundaries
      start_dl();
      send_byte(8'd0, 25'h00000, 8'h01);
      send_byte(8'd0, 25'h07FFF, 8'hFF);
      send_byte(8'd0, 25'h0E123, 8'h5A);
      send_byte(8'd0, 25'h1FFFF, 8'hA5);
      check_val("sum4", checksum, 16'h01FF);
      check_val("count4", byte_count, 25'd4);
      check_val("oor4", oor_err, 1'b0);
      send_byte(8'd0, 25'h09000, 8'h10);
      check_val("oor_9000", oor_err, 1'b1);
      check_val("count5", byte_count, 25'd5);
      end_dl_wait_ready();

      // Side-channel bytes while READY
      ioctl_download = 1'b1;
      send_byte(8'd1, 25'd0, 8'h04);
      send_byte(8'd254, 25'd0, 8'h3C);
      send_byte(8'd254, 25'd8, 8'h11);
      for (int i = 0; i < 6; i++) send_byte(8'd254, 25'($urandom_range(0, 15)), 8'($urandom));
      check_val("mod_04", mod, 8'h04);
      check_val("side_ready", rom_ready, 1'b1);
      check_val("side_core_reset", core_reset, 1'b0);
      check_val("side_count", byte_count, 25'd5);
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      check_val("side_ready_after", rom_ready, 1'b1);

      // Re-download from READY with random back-to-back bytes
      start_dl();
      for (int i = 0; i < 60; i++) send_byte(8'd0, rand_addr(), 8'($urandom));
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_sys); #1;
         check_val("hold_not_ready", rom_ready, 1'b0);
      end
      start_dl();
      for (int i = 0; i < 25; i++) begin
         @(posedge clk_sys); #1;
         check_val("reload_not_ready", rom_ready, 1'b0);
      end
      for (int i = 0; i < 20; i++) send_byte(8'd0, rand_addr(), 8'($urandom));
      end_dl_wait_ready();

      // Reset coinciding with an in-flight CPU write during LOAD
      start_dl();
      send_byte(8'd0, 25'h00200, 8'h33);
      ioctl_addr = 25'h00100; ioctl_dout = 8'h77; ioctl_wr = 1'b1; reset = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0; reset = 1'b0; ioctl_download = 1'b0;
      model_clear_all();
      check_val("rstld_cpu_wr", cpu_wr, 1'b0);
      check_val("rstld_checksum", checksum, 16'd0);
      check_val("rstld_count", byte_count, 25'd0);
      check_val("rstld_mod", mod, 8'd0);
      check_val("rstld_dip", dip_sw, 64'd0);
      check_val("rstld_core_reset", core_reset, 1'b1);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_sys); #1;
         check_val("rstld_strobes", {cpu_wr, snd_wr, wav_wr}, 3'b000);
         check_val("rstld_idle", rom_ready, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
